// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction controller for the Scpu datapath: sequences fetch/decode/execute,
// drives ALU/datapath selects and handshakes with the shared memory port (with timeout abort).
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] alu_result,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic        bus_err,
    output logic [3:0]  state
);
    localparam int unsigned CNT_W = 8;

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] EXEC_R  = 4'd2;
    localparam logic [3:0] WB_R    = 4'd3;
    localparam logic [3:0] MEMADDR = 4'd4;
    localparam logic [3:0] MEM_RD  = 4'd5;
    localparam logic [3:0] WB_MEM  = 4'd6;
    localparam logic [3:0] MEM_WR  = 4'd7;
    localparam logic [3:0] BRANCH  = 4'd8;
    localparam logic [3:0] JUMP    = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_OR    = 6'h25;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_EQ  = 3'b011;

    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic [CNT_W-1:0] wait_q;
    logic [CNT_W-1:0] wait_d;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             rtype_ok;
    logic             timeout_c;
    logic             unused_bits;

    assign op          = instr[31:26];
    assign funct       = instr[5:0];
    assign unused_bits = ^{instr[25:6], alu_result[31:1]};
    assign rtype_ok    = (op == OP_RTYPE) &&
                         ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_OR));
    assign timeout_c   = !mem_ready && (wait_q == CNT_W'(TIMEOUT - 1));
    assign state       = state_q;

    // State and memory-wait counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state and control decode; reset holds every output low
    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;

        if (!rst) begin
            case (state_q)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = DECODE;
                    end else if (timeout_c) begin
                        bus_err = 1'b1;
                    end else begin
                        wait_d = wait_q + CNT_W'(1);
                    end
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    if (rtype_ok) begin
                        state_d = EXEC_R;
                    end else if ((op == OP_LW) || (op == OP_SW)) begin
                        state_d = MEMADDR;
                    end else if (op == OP_BEQ) begin
                        state_d = BRANCH;
                    end else if (op == OP_J) begin
                        state_d = JUMP;
                    end else begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                end
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    case (funct)
                        FN_SUB:  alu_op = ALU_SUB;
                        FN_OR:   alu_op = ALU_OR;
                        default: alu_op = ALU_ADD;
                    endcase
                    state_d = WB_R;
                end
                WB_R: begin
                    reg_we  = 1'b1;
                    reg_dst = 1'b1;
                    state_d = FETCH;
                end
                MEMADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (op == OP_LW) ? MEM_RD : MEM_WR;
                end
                MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        state_d = WB_MEM;
                    end else if (timeout_c) begin
                        bus_err = 1'b1;
                        state_d = FETCH;
                    end else begin
                        wait_d = wait_q + CNT_W'(1);
                    end
                end
                WB_MEM: begin
                    reg_we     = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = FETCH;
                end
                MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        state_d = FETCH;
                    end else if (timeout_c) begin
                        bus_err = 1'b1;
                        state_d = FETCH;
                    end else begin
                        wait_d = wait_q + CNT_W'(1);
                    end
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_EQ;
                    pc_src    = 2'b01;
                    pc_we     = alu_result[0];
                    state_d   = FETCH;
                end
                JUMP: begin
                    pc_src  = 2'b10;
                    pc_we   = 1'b1;
                    state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control unit for the Scpu datapath. It owns the instruction state machine and drives the 3-bit ALU operation code: 000 add, 001 sub, 010 or, 011 equality (result 1 if a==b). It also generates all datapath and memory-port control, and handshakes with a single shared instruction/data memory port.

Parameters:
TIMEOUT, 16, maximum cycles spent in one memory-wait state with mem_ready low before the access is aborted (valid range 2..255).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
instr  input  32  current instruction register contents (MIPS encoding)
alu_result  input  32  ALU output; only bit 0 is used, in BRANCH
mem_ready  input  1  memory access complete this cycle
mem_req  output  1  memory access request
mem_we  output  1  memory write strobe (qualifies mem_req)
iord  output  1  address select: 0 = PC, 1 = ALU-out register
ir_we  output  1  instruction register load
pc_we  output  1  PC load
pc_src  output  2  PC source: 00 = ALU, 01 = ALU-out register, 10 = jump target
alu_src_a  output  1  ALU a: 0 = PC, 1 = register A
alu_src_b  output  2  ALU b: 00 = register B, 01 = constant 4, 10 = sext(imm), 11 = sext(imm)<<2
alu_op  output  3  ALU operation code
reg_we  output  1  register file write
reg_dst  output  1  destination: 0 = rt, 1 = rd
mem_to_reg  output  1  write-back source: 0 = ALU-out register, 1 = memory data register
illegal  output  1  one-cycle pulse on an unsupported opcode/funct
bus_err  output  1  one-cycle pulse on a memory timeout
state  output  4  current state, for debug

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- While rst is high: state = FETCH, wait counter = 0, all outputs forced to 0.
- Output timing: outputs are combinational from the state register. Any output not listed for a state is 0.
- Decoded instructions: R-type (op 0x00) with funct 0x20 add, 0x22 sub, 0x25 or; lw 0x23; sw 0x2B; beq 0x04; j 0x02.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000. When mem_ready=1: ir_we=1, pc_we=1, pc_src=00, go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALU-out).
  - R-type with a valid funct -> EXEC_R; lw/sw -> MEMADDR; beq -> BRANCH; j -> JUMP.
  - Anything else: illegal=1 for this cycle, go to FETCH. The PC has already advanced.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op = 000/001/010 per funct, go to WB_R.
- WB_R: reg_we=1, reg_dst=1, mem_to_reg=0, go to FETCH.
- MEMADDR: alu_src_a=1, alu_src_b=10, alu_op=000; lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_req=1, iord=1; on mem_ready go to WB_MEM.
- WB_MEM: reg_we=1, reg_dst=0, mem_to_reg=1, go to FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1; on mem_ready go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=011, pc_src=01, pc_we=alu_result[0], go to FETCH.
- JUMP: pc_src=10, pc_we=1, go to FETCH.
- Handshake: mem_req stays high and the address/strobe stay stable until the cycle in which mem_ready=1. mem_ready is ignored in all non-memory states.
- Wait counter:
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - Clears on every state change.
  - When it equals TIMEOUT-1 and mem_ready=0: bus_err=1 for that cycle, go to FETCH with no ir_we/pc_we/reg_we.
  - A timeout in FETCH retries the same PC. mem_ready=1 in the timeout cycle takes priority and completes normally.
- Latency with zero-wait memory: R-type 4 cycles, lw 5, sw 4, beq 3, j 3.
- Asynchronous reset mid-instruction abandons the instruction; no partial reg_we/pc_we is issued after rst falls.

Test Plan:
- Reset, then add (0x00430820) with mem_ready tied to 1 -> states FETCH, DECODE, EXEC_R, WB_R, FETCH; alu_op=000 in EXEC_R; reg_we=1, reg_dst=1 in WB_R.
- sub/or funct 0x22/0x25 -> alu_op=001/010 in EXEC_R; lw (0x8C220004) with mem_ready delayed 3 cycles in MEM_RD -> mem_req/iord held 4 cycles, then WB_MEM with mem_to_reg=1.
- beq with alu_result=1 -> pc_we=1, pc_src=01 in BRANCH. beq with alu_result=0 -> pc_we=0; next state FETCH in both cases.
- Opcode 0x3F, and R-type with funct 0x21 -> illegal pulses exactly 1 cycle in DECODE, next state FETCH, no reg_we.
- mem_ready held 0 in MEM_WR with TIMEOUT=16 -> bus_err high on the 16th wait cycle, return to FETCH. Repeat with mem_ready=1 on that cycle -> no bus_err.
- Assert rst during MEM_RD -> outputs drop to 0 asynchronously; after release the first cycle is FETCH with mem_req=1.
